// File: rtl/weight_stream_sched.sv
// weight_stream_sched: streams one layer's coefficient ROM into an ap_fifo
// output, sweeping addresses 0..MEM_SIZE-1 NUM_PASSES times per start.
// Up to one word per cycle is sustained, and downstream backpressure is honoured.
//
// Ports:
//   ap_clk, ap_rst            clock, synchronous active-high reset
//   ap_start/ap_idle/ap_done  block-level handshake toward the layer controller
//   weight_address/weight_ce  ROM read port (data returns on weight_q one cycle later)
//   weight_q                  ROM read data
//   output_V_din/_write       stream data and write strobe
//   output_V_full_n           downstream not-full
//   cfg_num_passes            (WEIGHT_PASS_CFG_EN only) run-time pass count, 0 acts as 1
//
// Optional feature macro: WEIGHT_PASS_CFG_EN
module weight_stream_sched #(
    parameter int unsigned MEM_SIZE   = 288,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned NUM_PASSES = 4,
    parameter int unsigned ADDR_W     = $clog2(MEM_SIZE)
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  ap_start,
    output logic                  ap_idle,
    output logic                  ap_done,
    output logic [ADDR_W-1:0]     weight_address,
    output logic                  weight_ce,
    input  logic [DATA_WIDTH-1:0] weight_q,
`ifdef WEIGHT_PASS_CFG_EN
    input  logic [7:0]            cfg_num_passes,
`endif
    output logic [DATA_WIDTH-1:0] output_V_din,
    input  logic                  output_V_full_n,
    output logic                  output_V_write
);

`ifdef WEIGHT_PASS_CFG_EN
    localparam int unsigned PASS_W = 8;
`else
    localparam int unsigned PASS_W = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
`endif
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(MEM_SIZE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                  state, state_next;
    logic [ADDR_W-1:0]       addr;
    logic [PASS_W-1:0]       pass_cnt;
    logic [PASS_W-1:0]       last_pass;
    logic [DATA_WIDTH-1:0]   fifo_mem [2];
    logic                    rd_ptr, wr_ptr;
    logic [1:0]              occ, occ_next;
    logic                    in_flight;
    logic                    pop, push, issue, last_issue;

    assign weight_address = addr;

    // State register
    always_ff @(posedge ap_clk) begin
        if (ap_rst) state <= IDLE;
        else        state <= state_next;
    end

    // Next state, read issue and stream outputs
    always_comb begin
        state_next     = state;
        issue          = 1'b0;
        weight_ce      = 1'b0;
        pop            = (occ != 2'd0) && output_V_full_n && !ap_rst;
        push           = in_flight;
        occ_next       = occ - 2'(pop) + 2'(push);
        last_issue     = (addr == ADDR_LAST) && (pass_cnt == last_pass);
        output_V_write = pop;
        output_V_din   = (occ != 2'd0) ? fifo_mem[rd_ptr] : '0;

        case (state)
            IDLE: begin
                if (ap_start) state_next = RUN;
            end
            RUN: begin
                // A same-cycle pop frees its slot, so issue can keep pace with writes
                if (((occ - 2'(pop) + 2'(in_flight)) < 2'd2) && !ap_rst) begin
                    issue     = 1'b1;
                    weight_ce = 1'b1;
                    if (last_issue) state_next = DRAIN;
                end
            end
            DRAIN: begin
                // Leave once the final word is being written this cycle
                if (!in_flight && (occ_next == 2'd0)) state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Handshake flags decoded from the next state so they are flop outputs
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            ap_idle <= 1'b1;
            ap_done <= 1'b0;
        end else begin
            ap_idle <= (state_next == IDLE);
            ap_done <= (state_next == DONE);
        end
    end

    // Address/pass counters, read tracking and 2-entry data buffer
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            addr        <= '0;
            pass_cnt    <= '0;
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            occ         <= 2'd0;
            in_flight   <= 1'b0;
`ifdef WEIGHT_PASS_CFG_EN
            last_pass   <= PASS_W'(NUM_PASSES - 1);
`endif
        end else begin
            in_flight <= issue;
            occ       <= occ_next;
            if (push) begin
                fifo_mem[wr_ptr] <= weight_q;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;

            if ((state == IDLE) && ap_start) begin
                addr     <= '0;
                pass_cnt <= '0;
`ifdef WEIGHT_PASS_CFG_EN
                last_pass <= (cfg_num_passes == 8'd0) ? 8'd0 : cfg_num_passes - 8'd1;
`endif
            end else if (issue) begin
                if (addr == ADDR_LAST) begin
                    addr     <= '0;
                    pass_cnt <= pass_cnt + PASS_W'(1);
                end else begin
                    addr <= addr + ADDR_W'(1);
                end
            end
        end
    end

`ifndef WEIGHT_PASS_CFG_EN
    assign last_pass = PASS_W'(NUM_PASSES - 1);
`endif

endmodule

// File: tb/tb_weight_stream_sched.sv
// Directed bench for weight_stream_sched with MEM_SIZE=4, NUM_PASSES=2 and a
// small behavioural ROM (one-cycle read latency).
module tb_weight_stream_sched;

    localparam int unsigned MEM_SIZE = 4;
    localparam int unsigned DW       = 16;
    localparam int unsigned AW       = 2;

    logic          ap_clk = 1'b0;
    logic          ap_rst;
    logic          ap_start;
    logic          ap_idle;
    logic          ap_done;
    logic [AW-1:0] weight_address;
    logic          weight_ce;
    logic [DW-1:0] weight_q = '0;
    logic [DW-1:0] output_V_din;
    logic          output_V_full_n;
    logic          output_V_write;
`ifdef WEIGHT_PASS_CFG_EN
    logic [7:0]    cfg_num_passes = 8'd2;
`endif

    logic [DW-1:0] rom [4] = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int t0     = 0;

    logic [DW-1:0] wq[$];
    int            wcyc[$];
    int            dq[$];
    int            rd_cnt, wr_cnt, max_out, viol;

    weight_stream_sched #(
        .MEM_SIZE  (MEM_SIZE),
        .DATA_WIDTH(DW),
        .NUM_PASSES(2)
    ) dut (
        .ap_clk         (ap_clk),
        .ap_rst         (ap_rst),
        .ap_start       (ap_start),
        .ap_idle        (ap_idle),
        .ap_done        (ap_done),
        .weight_address (weight_address),
        .weight_ce      (weight_ce),
        .weight_q       (weight_q),
`ifdef WEIGHT_PASS_CFG_EN
        .cfg_num_passes (cfg_num_passes),
`endif
        .output_V_din   (output_V_din),
        .output_V_full_n(output_V_full_n),
        .output_V_write (output_V_write)
    );

    always #5 ap_clk = ~ap_clk;

    always @(posedge ap_clk) begin
        cyc <= cyc + 1;
        if (weight_ce) weight_q <= rom[weight_address];
    end

    // Observe the stream mid-cycle, after inputs have settled
    always @(negedge ap_clk) begin
        if (weight_ce) rd_cnt++;
        if (output_V_write) begin
            wr_cnt++;
            wq.push_back(output_V_din);
            wcyc.push_back(cyc);
            if (!output_V_full_n) viol++;
        end
        if (rd_cnt - wr_cnt > max_out) max_out = rd_cnt - wr_cnt;
        if (ap_done) dq.push_back(cyc);
    end

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic clear_mon();
        wq.delete();
        wcyc.delete();
        dq.delete();
        rd_cnt  = 0;
        wr_cnt  = 0;
        max_out = 0;
        viol    = 0;
    endtask

    task automatic test_reset();
        ap_rst = 1'b1; ap_start = 1'b0; output_V_full_n = 1'b1;
        tick(); tick(); #1;
        checks++; if (ap_idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b expected 1", ap_idle); end
        checks++; if (ap_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", ap_done); end
        checks++; if (weight_ce !== 1'b0) begin errors++; $display("FAIL reset_ce: got %b expected 0", weight_ce); end
        checks++; if (weight_address !== 2'd0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", weight_address); end
        checks++; if (output_V_write !== 1'b0) begin errors++; $display("FAIL reset_write: got %b expected 0", output_V_write); end
        checks++; if (output_V_din !== 16'h0) begin errors++; $display("FAIL reset_din: got %h expected 0", output_V_din); end
        tick(); ap_rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        tick(); clear_mon(); ap_start = 1'b1; t0 = cyc;
        for (int c = 1; c <= 14; c++) begin
            tick(); ap_start = 1'b0; #1;
            if (c == 1) begin
                checks++; if (weight_ce !== 1'b1) begin errors++; $display("FAIL basic_first_ce: got %b expected 1", weight_ce); end
                checks++; if (weight_address !== 2'd0) begin errors++; $display("FAIL basic_first_addr: got %0d expected 0", weight_address); end
            end
            if (c == 12) begin
                checks++; if (ap_idle !== 1'b1) begin errors++; $display("FAIL basic_idle_after: got %b expected 1", ap_idle); end
            end
        end
        checks++; if (wq.size() != 8) begin errors++; $display("FAIL basic_count: got %0d expected 8", wq.size()); end
        for (int i = 0; i < 8; i++) begin
            if (i < wq.size()) begin
                checks++; if (wq[i] !== rom[i % 4]) begin errors++; $display("FAIL basic_word[%0d]: got %h expected %h", i, wq[i], rom[i % 4]); end
                checks++; if (wcyc[i] - t0 != 3 + i) begin errors++; $display("FAIL basic_wcycle[%0d]: got %0d expected %0d", i, wcyc[i] - t0, 3 + i); end
            end
        end
        checks++; if (dq.size() != 1) begin errors++; $display("FAIL basic_done_count: got %0d expected 1", dq.size()); end
        if (dq.size() > 0) begin
            checks++; if (dq[0] - t0 != 11) begin errors++; $display("FAIL basic_done_cycle: got %0d expected 11", dq[0] - t0); end
        end
    endtask

    task automatic test_backpressure();
        tick(); clear_mon(); ap_start = 1'b1; t0 = cyc;
        for (int c = 1; c <= 25; c++) begin
            tick(); ap_start = 1'b0;
            output_V_full_n = !(c >= 4 && c <= 7);
        end
        output_V_full_n = 1'b1;
        checks++; if (wq.size() != 8) begin errors++; $display("FAIL bp_count: got %0d expected 8", wq.size()); end
        for (int i = 0; i < 8; i++) begin
            if (i < wq.size()) begin
                checks++; if (wq[i] !== rom[i % 4]) begin errors++; $display("FAIL bp_word[%0d]: got %h expected %h", i, wq[i], rom[i % 4]); end
            end
        end
        checks++; if (viol != 0) begin errors++; $display("FAIL bp_write_when_full: got %0d expected 0", viol); end
        checks++; if (max_out > 2) begin errors++; $display("FAIL bp_outstanding: got %0d expected <=2", max_out); end
        checks++; if (dq.size() != 1) begin errors++; $display("FAIL bp_done_count: got %0d expected 1", dq.size()); end
    endtask

    task automatic test_reset_mid();
        tick(); clear_mon(); ap_start = 1'b1; t0 = cyc;
        for (int c = 1; c <= 5; c++) begin
            tick(); ap_start = 1'b0;
            if (c == 5) ap_rst = 1'b1;
        end
        tick(); ap_rst = 1'b0; #1;
        checks++; if (weight_ce !== 1'b0) begin errors++; $display("FAIL rstmid_ce: got %b expected 0", weight_ce); end
        checks++; if (weight_address !== 2'd0) begin errors++; $display("FAIL rstmid_addr: got %0d expected 0", weight_address); end
        checks++; if (output_V_write !== 1'b0) begin errors++; $display("FAIL rstmid_write: got %b expected 0", output_V_write); end
        checks++; if (output_V_din !== 16'h0) begin errors++; $display("FAIL rstmid_din: got %h expected 0", output_V_din); end
        checks++; if (ap_idle !== 1'b1) begin errors++; $display("FAIL rstmid_idle: got %b expected 1", ap_idle); end
        for (int c = 0; c < 10; c++) tick();
        checks++; if (dq.size() != 0) begin errors++; $display("FAIL rstmid_no_done: got %0d expected 0", dq.size()); end
        test_basic();
    endtask

    task automatic test_back_to_back();
        tick(); clear_mon(); ap_start = 1'b1; t0 = cyc;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (c == 13) ap_start = 1'b0;
            #1;
            if (c == 12) begin
                checks++; if (ap_idle !== 1'b1) begin errors++; $display("FAIL b2b_idle_gap: got %b expected 1", ap_idle); end
            end
            if (c == 13) begin
                checks++; if (ap_idle !== 1'b0) begin errors++; $display("FAIL b2b_restart: got %b expected 0", ap_idle); end
            end
        end
        checks++; if (wq.size() != 16) begin errors++; $display("FAIL b2b_count: got %0d expected 16", wq.size()); end
        for (int i = 0; i < 16; i++) begin
            if (i < wq.size()) begin
                checks++; if (wq[i] !== rom[i % 4]) begin errors++; $display("FAIL b2b_word[%0d]: got %h expected %h", i, wq[i], rom[i % 4]); end
            end
        end
        checks++; if (dq.size() != 2) begin errors++; $display("FAIL b2b_done_count: got %0d expected 2", dq.size()); end
        if (dq.size() == 2) begin
            checks++; if (dq[0] - t0 != 11 || dq[1] - t0 != 23) begin errors++; $display("FAIL b2b_done_cycles: got %0d,%0d expected 11,23", dq[0] - t0, dq[1] - t0); end
        end
    endtask

    task automatic test_start_ignored();
        tick(); clear_mon(); ap_start = 1'b1; t0 = cyc;
        for (int c = 1; c <= 20; c++) begin
            tick();
            ap_start = (c == 5 || c == 9 || c == 11);
        end
        ap_start = 1'b0; #1;
        checks++; if (wq.size() != 8) begin errors++; $display("FAIL ign_count: got %0d expected 8", wq.size()); end
        checks++; if (dq.size() != 1) begin errors++; $display("FAIL ign_done_count: got %0d expected 1", dq.size()); end
        checks++; if (ap_idle !== 1'b1) begin errors++; $display("FAIL ign_idle: got %b expected 1", ap_idle); end
    endtask

`ifdef WEIGHT_PASS_CFG_EN
    task automatic test_cfg_passes();
        cfg_num_passes = 8'd3;
        tick(); clear_mon(); ap_start = 1'b1; t0 = cyc;
        for (int c = 1; c <= 20; c++) begin
            tick(); ap_start = 1'b0;
            if (c == 2) cfg_num_passes = 8'd1;
        end
        checks++; if (wq.size() != 12) begin errors++; $display("FAIL cfg3_count: got %0d expected 12", wq.size()); end
        checks++; if (dq.size() != 1 || (dq.size() == 1 && dq[0] - t0 != 15)) begin errors++; $display("FAIL cfg3_done: got %0d pulses expected 1 at 15", dq.size()); end
        cfg_num_passes = 8'd0;
        tick(); clear_mon(); ap_start = 1'b1; t0 = cyc;
        for (int c = 1; c <= 12; c++) begin
            tick(); ap_start = 1'b0;
        end
        checks++; if (wq.size() != 4) begin errors++; $display("FAIL cfg0_count: got %0d expected 4", wq.size()); end
        for (int i = 0; i < 4; i++) begin
            if (i < wq.size()) begin
                checks++; if (wq[i] !== rom[i]) begin errors++; $display("FAIL cfg0_word[%0d]: got %h expected %h", i, wq[i], rom[i]); end
            end
        end
        checks++; if (dq.size() != 1 || (dq.size() == 1 && dq[0] - t0 != 7)) begin errors++; $display("FAIL cfg0_done: got %0d pulses expected 1 at 7", dq.size()); end
        cfg_num_passes = 8'd2;
    endtask
`endif

    initial begin
        clear_mon();
        test_reset();
        test_basic();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_start_ignored();
`ifdef WEIGHT_PASS_CFG_EN
        test_cfg_passes();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/weight_stream_sched.md
Name: weight_stream_sched

Overview:
- Native-RTL sequencer for one layer's weight ROM. Replaces the HLS weight streamer between the coefficient ROM and the weight output stream (ap_fifo style).
- On each start it reads ROM addresses 0..MEM_SIZE-1, repeated NUM_PASSES times, and pushes every word into the downstream FIFO, honouring backpressure.
- Targets full throughput of 1 word/cycle and a clean start/done handshake toward the layer controller.

Parameters:
- MEM_SIZE, 288, number of coefficients in the ROM (kernel size of the layer).
- DATA_WIDTH, 16, coefficient width (matches coeff_width).
- NUM_PASSES, 4, number of complete ROM sweeps per start (must be ≥1).
- ADDR_W, $clog2(MEM_SIZE), derived ROM address width; do not override.

Ports:
- ap_clk  in  1  clock.
- ap_rst  in  1  synchronous reset, active-high.
- ap_start  in  1  start request, sampled only in IDLE.
- ap_idle  out  1  high while in IDLE.
- ap_done  out  1  single-cycle pulse when the last word has been written.
- weight_address  out  ADDR_W  ROM read address.
- weight_ce  out  1  ROM read enable.
- weight_q  in  DATA_WIDTH  ROM data, valid the cycle after weight_ce.
- output_V_din  out  DATA_WIDTH  stream data.
- output_V_full_n  in  1  downstream not-full.
- output_V_write  out  1  stream write strobe.

Behaviour:
- Reset values: weight_ce=0, weight_address=0, output_V_write=0, output_V_din=0, ap_done=0, ap_idle=1, state=IDLE. Address counter, pass counter and buffer are cleared; any in-flight ROM read is discarded.
- Reset mid-operation aborts immediately. No further writes occur, and ap_done is not pulsed.
- FSM:
  - IDLE: ap_start=1 → RUN.
  - RUN: issue reads; after issuing the last address of the last pass → DRAIN.
  - DRAIN: no reads issued; when buffer empty and no read in flight → DONE.
  - DONE: ap_done=1 for one cycle → IDLE.
- ap_start is ignored outside IDLE. If ap_start is still high in the IDLE cycle following DONE, a new run starts.
- Buffer: 2-entry FIFO holding ROM data.
  - A read is issued (weight_ce=1) in RUN only when buffer occupancy plus in-flight reads is less than 2. This guarantees no ROM data is ever lost.
  - weight_q is captured into the buffer at the end of the cycle after weight_ce.
- Output:
  - output_V_write = buffer non-empty AND output_V_full_n.
  - output_V_din = buffer head; it is 0 when the buffer is empty.
  - Pop occurs on write. Push and pop in the same cycle are allowed, with occupancy unchanged.
- Address sequencing:
  - The address increments per issued read and wraps MEM_SIZE-1 → 0.
  - Each wrap increments the pass counter.
  - Total words written per run = MEM_SIZE*NUM_PASSES, in order 0..MEM_SIZE-1 repeated.
- Latency: with ap_start high at cycle 0 (in IDLE):
  - cycle 1: weight_ce=1, address 0.
  - cycle 3: first output_V_write with word0.
- Throughput: with output_V_full_n held high, one write per cycle in steady state.
- ap_done asserts in the cycle after the final write.
- Backpressure: while full_n=0, reads stall once the buffer plus in-flight reads reach 2. Resumes without a bubble beyond one cycle.

Optional Feature:
- Macro: WEIGHT_PASS_CFG_EN.
- With the macro defined:
  - Adds input port cfg_num_passes (8 bits), sampled into a register on the IDLE→RUN transition.
  - The sampled value replaces NUM_PASSES; 0 is treated as 1.
  - Changes to the port during a run have no effect.
- Without the macro: no port; the pass count is the NUM_PASSES parameter.

Test Plan:
- MEM_SIZE=4, NUM_PASSES=2, ROM = 0x11,0x22,0x33,0x44, full_n=1, one-cycle ap_start → 8 writes on consecutive cycles 3..10: 11,22,33,44,11,22,33,44; ap_done pulse at cycle 11; ap_idle=1 from cycle 12.
- Same setup, full_n=0 during cycles 4–7 → at most 2 reads outstanding, no write while full_n=0, no word lost or duplicated, 8 words total in order.
- ap_rst asserted at cycle 5 mid-run → next cycle all outputs at reset values and state IDLE, no ap_done; a new ap_start gives the full 8-word sequence from word 0x11.
- ap_start held high continuously → back-to-back runs, each 8 words, with exactly one ap_done per run and one IDLE cycle between runs.
- ap_start pulsed during RUN → ignored; the word count stays 8.
- WEIGHT_PASS_CFG_EN defined, cfg_num_passes=3 (then changed to 1 mid-run) → 12 words, then ap_done; a later run with cfg=0 → 4 words.
